divider: RTL and testbench

Sequential restoring divider, the inverse arithmetic of the team's pipelined 4×4 multiplier. It divides an unsigned DIVIDEND_W-bit dividend by an unsigned DIVISOR_W-bit divisor and produces the quotient and remainder. It resolves one quotient bit per clock behind a start/done handshake. It sits beside the multiplier in the arithmetic datapath and can check the multiplier's products (S / b == a, remainder 0).

---
 rtl/divider.sv | 153 +++++++++++++++
 tb/tb_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock behind a
// start/done handshake. Unsigned DIVIDEND_W / DIVISOR_W division producing
// a DIVIDEND_W-bit quotient and a DIVISOR_W-bit remainder.
//
// Optional feature (macro DIVIDER_ZERO_CHECK_EN): a zero divisor bypasses the
// iterative loop, reports quotient = all ones, remainder = low dividend bits,
// and raises div_by_zero. Without the macro, div_by_zero is held at 0 and a
// zero divisor takes the normal DIVIDEND_W-cycle path, which yields the same
// quotient/remainder values naturally.
//
// Handshake: start is sampled only in IDLE; the rising edge that sees
// start=1 in IDLE (and reset=0) is the accept edge. busy is high while the
// FSM iterates; done is a one-cycle pulse marking quotient/remainder valid.
// Results are held until the next accept clears them.
module divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef DIVIDER_ZERO_CHECK_EN
  // One-cycle detour so a zero-divisor result lands one edge after accept.
  localparam logic [1:0] S_ZERO = 2'd3;
`endif

  logic [1:0]            state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q,       dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q,       dvs_d;
  logic [DIVISOR_W:0]    prem_q,      prem_d;
  logic [DIVIDEND_W-1:0] quo_q,       quo_d;
  logic [DIVIDEND_W-1:0] quotient_q,  quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q,       dbz_d;

  // Trial subtraction for the current iteration.
  logic [DIVISOR_W:0] trial_p;
  logic [DIVISOR_W:0] trial_diff;
  logic               trial_ge;

  // Shift the next dividend bit into the partial remainder and compare.
  always_comb begin
    trial_p    = {prem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    trial_diff = trial_p - {1'b0, dvs_q};
    trial_ge   = (trial_p >= {1'b0, dvs_q});
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d       = dividend;
          dvs_d       = divisor;
          prem_d      = '0;
          quo_d       = '0;
          cnt_d       = CNT_W'(DIVIDEND_W - 1);
          quotient_d  = '0;
          remainder_d = '0;
          dbz_d       = 1'b0;
          state_d     = S_RUN;
`ifdef DIVIDER_ZERO_CHECK_EN
          if (divisor == '0) state_d = S_ZERO;
`endif
        end
      end
      S_RUN: begin
        dvd_d  = dvd_q << 1;
        prem_d = trial_ge ? trial_diff : trial_p;
        quo_d  = {quo_q[DIVIDEND_W-2:0], trial_ge};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Remainder is < divisor here, so the low DIVISOR_W bits suffice.
          quotient_d  = quo_d;
          remainder_d = prem_d[DIVISOR_W-1:0];
          state_d     = S_DONE;
        end
      end
`ifdef DIVIDER_ZERO_CHECK_EN
      S_ZERO: begin
        quotient_d  = '1;
        remainder_d = dvd_q[DIVISOR_W-1:0];
        dbz_d       = 1'b1;
        state_d     = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (default 8/4 widths). Honours
// DIVIDER_ZERO_CHECK_EN when it is defined for the build.
module tb_divider;

`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expected results: {quotient[7:0], remainder[3:0], div_by_zero}.
  logic [12:0] exp_q[$];

  divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock block.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
  endtask

  function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    if (b == 4'd0) begin
      q = 8'hFF;
      r = a[3:0];
      z = ZC;
    end else begin
      q = a / {4'd0, b};
      r = 4'(a % {4'd0, b});
      z = 1'b0;
    end
    return {q, r, z};
  endfunction

  // Scoreboard: compare each done pulse against the oldest expectation.
  always @(negedge clock) begin
    logic [12:0] e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", {24'd0, quotient}, {24'd0, e[12:5]});
        check("remainder", {28'd0, remainder}, {28'd0, e[4:1]});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
      end
    end
  end

  // One division with latency/busy checks; optionally pokes start mid-run.
  task automatic run_one(input logic [7:0] a, input logic [3:0] b, input bit poke);
    logic [12:0] e;
    int k, nb, exp_lat, exp_busy;
    e        = model(a, b);
    exp_lat  = (b == 4'd0 && ZC) ? 1 : 8;
    exp_busy = (b == 4'd0 && ZC) ? 0 : 8;
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    exp_q.push_back(e);
    @(negedge clock);
    start    = 1'b0;
    dividend = 8'($urandom_range(0, 255));
    divisor  = 4'($urandom_range(0, 15));
    check("cleared_on_accept", {24'd0, quotient}, 32'd0);
    k = 0; nb = 0;
    while (!done && k < 40) begin
      if (busy) nb++;
      if (poke && k == 3) begin
        start = 1'b1; dividend = a ^ 8'h5A; divisor = (b == 4'd1) ? 4'd3 : 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", k, exp_lat);
      check("busy_cycles", nb, exp_busy);
      check("busy_at_done", {31'd0, busy}, 32'd0);
    end
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("hold_quotient", {24'd0, quotient}, {24'd0, e[12:5]});
    check("hold_remainder", {28'd0, remainder}, {28'd0, e[4:1]});
  endtask

  // Driver / sequence.
  initial begin
    int k, ndone, last_done;
    bit first;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {28'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // Directed cases.
    run_one(8'd200, 4'd7,  1'b0);
    run_one(8'd255, 4'd15, 1'b0);
    run_one(8'd5,   4'd9,  1'b0);
    run_one(8'd0,   4'd1,  1'b0);
    run_one(8'd100, 4'd0,  1'b0);
    run_one(8'd255, 4'd1,  1'b0);
    // start pulsed mid-run must be ignored.
    run_one(8'd123, 4'd11, 1'b1);

    // Reset 4 cycles into a division, with start high on the reset edge.
    @(negedge clock);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", {24'd0, quotient}, 32'd0);
    check("midrst_remainder", {28'd0, remainder}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    run_one(8'd200, 4'd7, 1'b0);

    // A few random cases, including zero divisors.
    for (int i = 0; i < 6; i++)
      run_one(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b0);

    // Exhaustive nonzero divisors back-to-back with start held high.
    first = 1'b1; last_done = 0;
    start = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        dividend = 8'(a); divisor = 4'(b);
        exp_q.push_back(model(8'(a), 4'(b)));
        k = 0;
        while (!done && k < 30) begin
          @(negedge clock);
          k++;
        end
        if (!done) begin
          check("b2b_timeout", 32'd0, 32'd1);
        end else begin
          if (!first) check("b2b_period", cyc - last_done, 10);
          last_done = cyc;
          first = 1'b0;
        end
        @(negedge clock);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
